po2_weight_encode: RTL and testbench

Converts a signed fixed-point weight into the power-of-two form consumed by po2_multiply: a sign bit plus a right-shift amount, where weight ≈ ±2^-log_2_weight.
- Sits between weight storage and the po2 multiplier array; it is the encoder for that multiplier's decoder-style shift.
- Multi-cycle, leading-one scan with round-to-nearest.
- Valid/ready handshake on both sides.

---
 rtl/po2_pkg.sv | 28 ++
 rtl/po2_weight_encode.sv | 148 ++++++++++++++
 tb/tb_po2_weight_encode.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/po2_pkg.sv
// po2_pkg: definitions shared by the power-of-two weight encoder (po2_weight_encode)
// and the power-of-two multiplier (po2_multiply).
//   PO2_W / PO2_I / PO2_F : default weight width, integer bits and fractional bits
//   ZERO_SHIFT            : shift code reported for a zero weight (all ones)
//   po2_state_e           : encoder FSM states
//   one_fixed()           : fixed-point representation of 1.0 for a given W/I split
package po2_pkg;

    localparam int unsigned PO2_W = 16;
    localparam int unsigned PO2_I = 4;
    localparam int unsigned PO2_F = PO2_W - PO2_I;

    localparam logic [PO2_W-1:0] ZERO_SHIFT = '1;

    typedef enum logic [2:0] {
        StIdle,
        StAbs,
        StScan,
        StRound,
        StDone
    } po2_state_e;

    // 1.0 in Q(i).(w-i) is 2^(w-i).
    function automatic logic [31:0] one_fixed(input int unsigned w, input int unsigned i);
        return 32'd1 << (w - i);
    endfunction

endpackage

// File: rtl/po2_weight_encode.sv
// po2_weight_encode: converts a signed Q(I).(F) weight into sign + right-shift form,
// |weight| ~= 2^-log_2_weight, rounding the leading-one position to the nearest power.
// The leading-one search is sequential: one shift per cycle.
// Ports:
//   clk, rst        : clock; asynchronous active-high reset
//   in_v, in_ready  : input handshake (in_ready only while idle)
//   weight          : signed Q(I).(F) weight, sampled on accept
//   out_v, out_ready: output handshake; results held while out_ready is low
//   negative_weight : weight < 0
//   log_2_weight    : shift amount k
//   is_zero         : weight == 0; log_2_weight is all ones and carries no meaning
//   clipped         : |weight| > 1.0, saturated to shift 0
module po2_weight_encode
    import po2_pkg::*;
#(
    parameter int unsigned W = PO2_W,
    parameter int unsigned I = PO2_I
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_v,
    output logic                in_ready,
    input  logic signed [W-1:0] weight,
    output logic                out_v,
    input  logic                out_ready,
    output logic                negative_weight,
    output logic [W-1:0]        log_2_weight,
    output logic                is_zero,
    output logic                clipped
);

    localparam int unsigned FracW = W - I;
    localparam logic [W-1:0] One = W'(one_fixed(W, I));

    po2_state_e     state_q, state_d;
    logic [W-1:0]   weight_q, weight_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   k_q, k_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   log2_q, log2_d;
    logic           zero_q, zero_d;
    logic           clip_q, clip_d;
    logic           out_v_q, out_v_d;
    logic [W-1:0]   mag;

    // Two's-complement magnitude; the most negative value maps to 2^(W-1) unsigned.
    assign mag = weight_q[W-1] ? (~weight_q + W'(1)) : weight_q;

    always_comb begin
        state_d  = state_q;
        weight_d = weight_q;
        m_d      = m_q;
        k_d      = k_q;
        neg_d    = neg_q;
        log2_d   = log2_q;
        zero_d   = zero_q;
        clip_d   = clip_q;
        out_v_d  = out_v_q;

        case (state_q)
            StIdle: begin
                if (in_v) begin
                    weight_d = weight;
                    state_d  = StAbs;
                end
            end
            StAbs: begin
                neg_d = weight_q[W-1];
                if (mag == '0) begin
                    zero_d  = 1'b1;
                    neg_d   = 1'b0;
                    log2_d  = '1;
                    state_d = StDone;
                end else if (mag >= One) begin
                    log2_d  = '0;
                    clip_d  = (mag > One);
                    state_d = StDone;
                end else begin
                    m_d     = mag;
                    k_d     = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (m_q >= One) begin
                    state_d = StRound;
                end else begin
                    m_d = m_q << 1;
                    k_d = k_q + W'(1);
                end
            end
            StRound: begin
                // Mantissa >= 1.5 (ties included) rounds up to the next larger power,
                // i.e. one less shift. k >= 1 here because mag < 1.0 reached SCAN.
                log2_d  = m_q[FracW-1] ? (k_q - W'(1)) : k_q;
                out_v_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                // Zero/clip results arrive from ABS with out_v still low; raising it one
                // edge later gives those fast paths a fixed two-edge latency.
                if (!out_v_q) begin
                    out_v_d = 1'b1;
                end else if (out_ready) begin
                    out_v_d = 1'b0;
                    zero_d  = 1'b0;
                    clip_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            weight_q <= '0;
            m_q      <= '0;
            k_q      <= '0;
            neg_q    <= 1'b0;
            log2_q   <= '0;
            zero_q   <= 1'b0;
            clip_q   <= 1'b0;
            out_v_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            weight_q <= weight_d;
            m_q      <= m_d;
            k_q      <= k_d;
            neg_q    <= neg_d;
            log2_q   <= log2_d;
            zero_q   <= zero_d;
            clip_q   <= clip_d;
            out_v_q  <= out_v_d;
        end
    end

    assign in_ready        = (state_q == StIdle);
    assign out_v           = out_v_q;
    assign negative_weight = neg_q;
    assign log_2_weight    = log2_q;
    assign is_zero         = zero_q;
    assign clipped         = clip_q;

endmodule

// File: tb/tb_po2_weight_encode.sv
// Testbench for po2_weight_encode (W=16, I=4): scoreboard of expected results pushed at
// drive time and popped when out_v rises.
module tb_po2_weight_encode;
    import po2_pkg::*;

    localparam int unsigned W  = PO2_W;
    localparam int unsigned FB = PO2_F;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_v;
    logic         in_ready;
    logic [W-1:0] weight;
    logic         out_v;
    logic         out_ready;
    logic         negative_weight;
    logic [W-1:0] log_2_weight;
    logic         is_zero;
    logic         clipped;

    po2_weight_encode #(.W(16), .I(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_v            (in_v),
        .in_ready        (in_ready),
        .weight          (weight),
        .out_v           (out_v),
        .out_ready       (out_ready),
        .negative_weight (negative_weight),
        .log_2_weight    (log_2_weight),
        .is_zero         (is_zero),
        .clipped         (clipped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic        neg;
        logic        zero;
        logic        clip;
        logic [15:0] log2;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference: leading-one bit position p gives k = F - p; the bit below it decides rounding.
    function automatic exp_t model(input logic [15:0] w);
        exp_t e;
        logic [15:0] mag;
        int p;
        int k;
        e.w    = w;
        e.neg  = w[15];
        e.zero = 1'b0;
        e.clip = 1'b0;
        mag    = w[15] ? (~w + 16'd1) : w;
        if (mag == 16'd0) begin
            e.neg  = 1'b0;
            e.zero = 1'b1;
            e.log2 = ZERO_SHIFT;
            e.lat  = 2;
        end else if (mag >= 16'h1000) begin
            e.log2 = 16'd0;
            e.clip = (mag != 16'h1000);
            e.lat  = 2;
        end else begin
            p = 0;
            for (int b = 0; b < 16; b++) if (mag[b]) p = b;
            k = FB - p;
            e.log2 = 16'(k);
            if (p > 0) begin
                if (mag[p-1]) e.log2 = 16'(k - 1);
            end
            e.lat = k + 3;
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] w, input logic neg, input logic zero,
                                input logic clip, input logic [15:0] log2, input int lat);
        exp_t e;
        e.w = w; e.neg = neg; e.zero = zero; e.clip = clip; e.log2 = log2; e.lat = lat;
        return e;
    endfunction

    // Pushes the expectation, offers the weight, and counts edges after accept until out_v.
    // lat is -1 if out_v never arrives within the budget. With noise set, in_v and weight
    // are wiggled while the block is busy.
    task automatic drive_weight(input exp_t e, input bit noise, output int lat);
        sb.push_back(e);
        for (int i = 0; i < 50 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        in_v   = 1'b1;
        weight = e.w;
        @(posedge clk); #1;
        in_v = 1'b0;
        lat  = -1;
        for (int n = 1; n <= 40; n++) begin
            if (noise) begin
                in_v   = n[0];
                weight = ~e.w;
            end
            @(posedge clk); #1;
            if (out_v) begin
                lat = n;
                break;
            end
        end
        in_v = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_v = 1'b0; out_ready = 1'b0; weight = '0;
        #3;
        vectors++;
        if ({in_ready, out_v, negative_weight, is_zero, clipped, log_2_weight} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b v=%b neg=%b z=%b c=%b log2=%h, want 1 0 0 0 0 0000",
                     in_ready, out_v, negative_weight, is_zero, clipped, log_2_weight);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_table(input string name, input exp_t tbl[]);
        exp_t e;
        int lat;
        foreach (tbl[i]) begin
            drive_weight(tbl[i], 1'b0, lat);
            e = sb.pop_front();
            vectors++;
            if (lat !== e.lat) begin
                miscompares++;
                $display("FAIL %s_latency w=%h: got %0d edges, want %0d", name, e.w, lat, e.lat);
            end
            vectors++;
            if ({negative_weight, is_zero, clipped, log_2_weight} !== {e.neg, e.zero, e.clip, e.log2}) begin
                miscompares++;
                $display("FAIL %s_result w=%h: got neg=%b z=%b c=%b log2=%h, want neg=%b z=%b c=%b log2=%h",
                         name, e.w, negative_weight, is_zero, clipped, log_2_weight,
                         e.neg, e.zero, e.clip, e.log2);
            end
            release_result();
        end
    endtask

    task automatic test_rounding();
        exp_t tbl[] = '{
            mk(16'h0400, 1'b0, 1'b0, 1'b0, 16'd2, 5),
            mk(16'hFA00, 1'b1, 1'b0, 1'b0, 16'd1, 5),
            mk(16'h0500, 1'b0, 1'b0, 1'b0, 16'd2, 5),
            mk(16'h0C00, 1'b0, 1'b0, 1'b0, 16'd0, 4),
            mk(16'h0001, 1'b0, 1'b0, 1'b0, 16'd12, 15),
            mk(16'hFFFF, 1'b1, 1'b0, 1'b0, 16'd12, 15),
            mk(16'h0003, 1'b0, 1'b0, 1'b0, 16'd10, 14)
        };
        test_table("round", tbl);
    endtask

    task automatic test_zero_clip();
        exp_t tbl[] = '{
            mk(16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 2),
            mk(16'h1000, 1'b0, 1'b0, 1'b0, 16'h0000, 2),
            mk(16'h3000, 1'b0, 1'b0, 1'b1, 16'h0000, 2),
            mk(16'h8000, 1'b1, 1'b0, 1'b1, 16'h0000, 2),
            mk(16'hF000, 1'b1, 1'b0, 1'b0, 16'h0000, 2)
        };
        test_table("zero_clip", tbl);
    endtask

    task automatic test_random();
        exp_t tbl[];
        logic [15:0] w;
        tbl = new[16];
        foreach (tbl[i]) begin
            w = 16'($urandom) >> $urandom_range(0, 15);
            if (i[0]) w = -w;
            tbl[i] = model(w);
        end
        test_table("random", tbl);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        drive_weight(mk(16'h0001, 1'b0, 1'b0, 1'b0, 16'd12, 15), 1'b1, lat);
        e = sb.pop_front();
        vectors++;
        if (lat !== e.lat) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d edges, want %0d", lat, e.lat);
        end
        for (int c = 0; c < 10; c++) begin
            in_v   = c[0];
            weight = 16'h3000;
            vectors++;
            if ({out_v, in_ready, negative_weight, is_zero, clipped, log_2_weight} !==
                {1'b1, 1'b0, e.neg, e.zero, e.clip, e.log2}) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: got v=%b rdy=%b neg=%b z=%b c=%b log2=%h, want v=1 rdy=0 log2=%h",
                         c, out_v, in_ready, negative_weight, is_zero, clipped, log_2_weight, e.log2);
            end
            @(posedge clk); #1;
        end
        in_v = 1'b0;
        release_result();
        vectors++;
        if ({out_v, in_ready, is_zero, clipped} !== 4'b0100) begin
            miscompares++;
            $display("FAIL bp_release: got v=%b rdy=%b z=%b c=%b, want 0 1 0 0",
                     out_v, in_ready, is_zero, clipped);
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t tbl[] = '{mk(16'h0800, 1'b0, 1'b0, 1'b0, 16'd1, 4)};
        in_v = 1'b1; weight = 16'h0001;
        @(posedge clk); #1;
        in_v = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_v, in_ready, is_zero, clipped} !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_reset: got v=%b rdy=%b z=%b c=%b, want 0 1 0 0",
                     out_v, in_ready, is_zero, clipped);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            vectors++;
            if (out_v !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_reset_no_emit: got out_v=%b, want 0", out_v);
            end
        end
        test_table("after_reset", tbl);
    endtask

    task automatic test_back_to_back();
        exp_t tbl[] = '{
            mk(16'h0400, 1'b0, 1'b0, 1'b0, 16'd2, 5),
            mk(16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 2),
            mk(16'hFD00, 1'b1, 1'b0, 1'b0, 16'd2, 6)
        };
        test_table("b2b", tbl);
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_zero_clip();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
